serial_adder: RTL and testbench

// Bit-serial N-bit adder built around the existing 1-bit full adder `fa`.
// `fa` has ports a, b, cin, sum and carry. serial_adder instantiates exactly one `fa`.

---
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first over WIDTH
// clocks, with the carry closed through a register and the sum collected in a shift register.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] r_next;

  fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (c_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Partial result after this bit; its top WIDTH-1 bits feed back, all WIDTH bits on completion.
  assign r_next = {fa_sum, r_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c_reg <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          r_sr  <= r_next[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_reg <= fa_carry;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= r_next;
            cout  <= fa_carry;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16, checked against
// plain integer addition and the documented done/busy timing.

module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8 busy=%b done=%b cout=%b sum=%h required all 0", busy8, done8, cout8, sum8);
    end
    vectors++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset16 busy=%b done=%b cout=%b sum=%h required all 0", busy16, done16, cout16, sum16);
    end
    rst = 1'b0;
    tick();
  endtask

  // One directed add on the 8-bit instance; checks latency, single done pulse, busy and result.
  task automatic add8(input string name, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit poke_start);
    logic [8:0] expv;
    int         lat;
    int         pulses;
    expv = {1'b0, a} + {1'b0, b} + 9'(c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      if (poke_start && n >= 3 && n <= 5) begin
        start8 = 1'b1; a8 = 8'h11;
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (done8) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          vectors++;
          if ({cout8, sum8} !== expv) begin
            miscompares++;
            $display("FAIL %s_result got %h required %h", name, {cout8, sum8}, expv);
          end
        end
      end
      if (lat < 0 || n == lat) begin
        vectors++;
        if (busy8 !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_busy cycle %0d got %b required 1", name, n, busy8);
        end
      end
    end
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL %s_latency got %0d required 8", name, lat);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL %s_pulses got %0d required 1", name, pulses);
    end
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_busy got %b required 0", name, busy8);
    end
  endtask

  task automatic test_basic();
    add8("basic", 8'h3C, 8'h42, 1'b0, 1'b0);
  endtask

  task automatic test_ripple();
    add8("ripple_ff01", 8'hFF, 8'h01, 1'b0, 1'b0);
    add8("ripple_a55a", 8'hA5, 8'h5A, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    add8("busy_start", 8'h3C, 8'h42, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    a8 = 8'hF0; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs busy=%b done=%b cout=%b sum=%h required all 0", busy8, done8, cout8, sum8);
    end
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done8) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midreset_done got %0d pulses required 0", pulses);
    end
    add8("after_reset", 8'h01, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int times[$];
    a8 = 8'h5D; b8 = 8'h7B; cin8 = 1'b1; start8 = 1'b1;
    for (int n = 0; n < 60 && times.size() < 3; n++) begin
      tick();
      if (done8) begin
        times.push_back(n);
        vectors++;
        if ({cout8, sum8} !== 9'h0D9) begin
          miscompares++;
          $display("FAIL b2b_result got %h required 0d9", {cout8, sum8});
        end
      end
    end
    start8 = 1'b0;
    vectors++;
    if (times.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count got %0d pulses required 3", times.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (times[i] - times[i-1] != 10) begin
          miscompares++;
          $display("FAIL b2b_spacing got %0d required 10", times[i] - times[i-1]);
        end
      end
    end
    tick();
    tick();
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop busy got %b required 0", busy8);
    end
  endtask

  task automatic test_random8();
    logic [8:0] expv, prev;
    int         lat;
    prev = {cout8, sum8};
    for (int v = 0; v < 500; v++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      expv = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
      start8 = 1'b1;
      tick();
      lat = -1;
      for (int n = 1; n <= 30 && lat < 0; n++) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
        tick();
        if (done8) lat = n;
        else if ({cout8, sum8} !== prev) begin
          vectors++;
          miscompares++;
          $display("FAIL rnd8_hold got %h required %h", {cout8, sum8}, prev);
        end
      end
      start8 = 1'b0;
      vectors++;
      if (lat != 8 || {cout8, sum8} !== expv) begin
        miscompares++;
        $display("FAIL rnd8 vec %0d lat %0d got %h required lat 8 value %h", v, lat, {cout8, sum8}, expv);
      end
      prev = expv;
      tick();
    end
  endtask

  task automatic test_random16();
    logic [16:0] expv, prev;
    int          lat;
    prev = {cout16, sum16};
    for (int v = 0; v < 500; v++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      expv = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
      start16 = 1'b1;
      tick();
      lat = -1;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'($urandom);
        tick();
        if (done16) lat = n;
        else if ({cout16, sum16} !== prev) begin
          vectors++;
          miscompares++;
          $display("FAIL rnd16_hold got %h required %h", {cout16, sum16}, prev);
        end
      end
      start16 = 1'b0;
      vectors++;
      if (lat != 16 || {cout16, sum16} !== expv) begin
        miscompares++;
        $display("FAIL rnd16 vec %0d lat %0d got %h required lat 16 value %h", v, lat, {cout16, sum16}, expv);
      end
      prev = expv;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random8();
    test_random16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
